uart_rx_deser: RTL

- Receive-side UART deserializer. Consumes the synchronized serial line fed from the pad-mux `uart_rxd` output and turns frames into bytes.
- Frame format: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
- Sampling is 16x oversampled with 3-sample majority vote per bit.
- Delivers each byte over a one-entry valid/ready holding register to the UART register block.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_cell.sv | 21 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_deser.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive/transmit blocks.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int OSR           = 16;
  localparam int SP_A          = 7;
  localparam int SP_B          = 8;
  localparam int SP_C          = 9;
  localparam int SP_LAST       = 15;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_DIV_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// Multi-flop metastability synchronizer with selectable reset level.
module sync_cell #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], i_d};
  end

  assign o_q = ff[STAGES-1];

endmodule

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every i_div+1 clocks, restartable via i_clr.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;
  logic             hit;

  // >= rather than == so a divisor lowered below the running count still wraps promptly
  assign hit    = (cnt >= i_div);
  assign o_tick = i_en && !i_clr && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (!i_en || i_clr || hit) cnt <= '0;
    else                            cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 16x oversampling, 3-sample majority, one-entry valid/ready output.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [DIV_W-1:0]     i_div,
  input  logic                 i_rxd,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_frm_err,
  output logic                 o_ovr_err
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                 i_par_odd,
  output logic                 o_par_err
`endif
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rxd_s, tick, clr, done, maj, at_9, at_15, par_ok;
  uart_state_e          state, state_d;
  logic [3:0]           sc, sc_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 s7, s8, s7_d, s8_d;

  sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .i_d(i_rxd), .o_q(rxd_s)
  );

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_clr(clr), .i_div(i_div), .o_tick(tick)
  );

  assign maj   = maj3(s7, s8, rxd_s);
  assign at_9  = tick && (sc == 4'(SP_C));
  assign at_15 = tick && (sc == 4'(SP_LAST));

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_d;
  assign par_ok = (par_bit == (^shift ^ i_par_odd));
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state;
    sc_d    = sc;
    idx_d   = idx;
    shift_d = shift;
    s7_d    = s7;
    s8_d    = s8;
    clr     = 1'b0;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit;
`endif
    if (tick) sc_d = sc + 4'd1;
    if (tick && sc == 4'(SP_A)) s7_d = rxd_s;
    if (tick && sc == 4'(SP_B)) s8_d = rxd_s;

    case (state)
      ST_IDLE: begin
        sc_d  = '0;
        idx_d = '0;
        // restart the divisor so sample points line up with the falling edge
        if (!rxd_s) begin
          state_d = ST_START;
          clr     = 1'b1;
        end
      end
      ST_START: begin
        if (at_9 && maj) state_d = ST_IDLE;
        else if (at_15) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_9) shift_d = {maj, shift[DATA_BITS-1:1]};
        if (at_15) begin
          if (idx == IDX_W'(DATA_BITS-1))
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          else
            idx_d = idx + IDX_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_9)  par_bit_d = maj;
        if (at_15) state_d   = ST_STOP;
      end
`endif
      ST_STOP: begin
        // decide at mid-stop so a back-to-back start bit is not missed
        if (at_9) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!i_en) begin
      state_d = ST_IDLE;
      sc_d    = '0;
      idx_d   = '0;
      clr     = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sc    <= '0;
      idx   <= '0;
      shift <= '0;
      s7    <= 1'b1;
      s8    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_d;
      sc    <= sc_d;
      idx   <= idx_d;
      shift <= shift_d;
      s7    <= s7_d;
      s8    <= s8_d;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_frm_err <= 1'b0;
      o_ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_par_err <= 1'b0;
`endif
    end else begin
      o_frm_err <= done && !maj;
      o_ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_par_err <= done && maj && !par_ok;
`endif
      if (done && maj && par_ok) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_ovr_err <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
